// File: rtl/tcam_cfg_ctrl.sv
// Memory-mapped TCAM / action-table configuration controller.
// Firmware fills key, mask and action staging registers over the PicoRV32
// native bus, then writes CMD; a small FSM turns the command into one or
// more single-cycle write strobes on the registered config outputs.
module tcam_cfg_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int          KEY_W     = 128,
   parameter int          ENTRIES   = 16,
   parameter int          ACTION_W  = 64,
   localparam int         IDX_W     = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                mem_valid,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   input  logic [3:0]          mem_wstrb,
   output logic                mem_ready,
   output logic [31:0]         mem_rdata,
   output logic                tcam_wr_en,
   output logic                tcam_wr_is_mask,
   output logic [IDX_W-1:0]    tcam_wr_addr,
   output logic [KEY_W-1:0]    tcam_wr_data,
   output logic                action_wr_en,
   output logic [IDX_W-1:0]    action_wr_addr,
   output logic [ACTION_W-1:0] action_wr_data,
   output logic                action_wr_default,
   output logic [ACTION_W-1:0] action_default_data
);

   localparam int KEY_WORDS   = KEY_W / 32;
   localparam int ACT_WORDS   = ACTION_W / 32;
   localparam int MASK_BASE   = KEY_WORDS;
   localparam int ACT_BASE    = 2 * KEY_WORDS;
   localparam int CMD_WORD    = ACT_BASE + ACT_WORDS;
   localparam int STATUS_WORD = CMD_WORD + 1;

   localparam logic [2:0] OP_KEY   = 3'd1;
   localparam logic [2:0] OP_MASK  = 3'd2;
   localparam logic [2:0] OP_ACT   = 3'd3;
   localparam logic [2:0] OP_DEF   = 3'd4;
   localparam logic [2:0] OP_ENTRY = 3'd5;

   typedef enum logic [2:0] {IDLE, WR_MASK, WR_KEY, WR_ACT, WR_DEF} state_e;

   state_e                state_q, state_d;
   logic [2:0]            op_q;
   logic [IDX_W-1:0]      idx_q;
   logic [KEY_W-1:0]      key_q, key_d, mask_q, mask_d;
   logic [ACTION_W-1:0]   act_q, act_d;
   logic                  err_q, err_d;
   logic [7:0]            done_q, done_d;
   logic                  ready_q, ready_d;
   logic [31:0]           rdata_q, rdata_d;

   logic                  tcam_en_q, tcam_en_d, is_mask_q, is_mask_d;
   logic [IDX_W-1:0]      tcam_addr_q, tcam_addr_d, act_addr_q, act_addr_d;
   logic [KEY_W-1:0]      tcam_data_q, tcam_data_d;
   logic                  act_en_q, act_en_d, def_en_q, def_en_d;
   logic [ACTION_W-1:0]   act_data_q, act_data_d, def_data_q, def_data_d;

   logic                  hit, busy, wr_acc, cmd_wr, cmd_err, w1c;
   int                    word;
   logic [2:0]            cmd_op;
   logic [IDX_W-1:0]      cmd_idx, cur_idx;

   // Bus decode: a write takes effect in the cycle mem_ready is high.
   always_comb begin
      hit     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
      word    = 32'(mem_addr[7:2]);
      busy    = (state_q != IDLE);
      wr_acc  = ready_q && hit && (mem_wstrb != 4'b0000);
      cmd_wr  = wr_acc && (word == CMD_WORD);
      cmd_op  = mem_wdata[10:8];
      cmd_idx = mem_wdata[IDX_W-1:0];
      cmd_err = cmd_wr && ((cmd_op == 3'd0) || (cmd_op > OP_ENTRY));
      w1c     = wr_acc && (word == STATUS_WORD) && mem_wstrb[0] && mem_wdata[1];
      // Accesses stall while a sequence runs so staging data stays stable.
      ready_d = hit && !ready_q && !busy;
   end

   // Staging register byte writes and read-data mux.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      key_d   = key_q;
      mask_d  = mask_q;
      act_d   = act_q;
      rdata_d = 32'h0;
      if (wr_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) begin
               if (word < MASK_BASE)
                  key_d[word*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
               else if (word < ACT_BASE)
                  mask_d[(word-MASK_BASE)*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
               else if (word < CMD_WORD)
                  act_d[(word-ACT_BASE)*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
         end
      end
      if (ready_d) begin
         if (word < MASK_BASE)
            rdata_d = key_q[word*32 +: 32];
         else if (word < ACT_BASE)
            rdata_d = mask_q[(word-MASK_BASE)*32 +: 32];
         else if (word < CMD_WORD)
            rdata_d = act_q[(word-ACT_BASE)*32 +: 32];
         else if (word == STATUS_WORD)
            rdata_d = {16'h0, done_q, 6'h0, err_q, busy};
      end
   end

   // Next-state logic: ENTRY walks MASK -> KEY -> ACT, single ops take one state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_wr) begin
               case (cmd_op)
                  OP_KEY:           state_d = WR_KEY;
                  OP_MASK, OP_ENTRY: state_d = WR_MASK;
                  OP_ACT:           state_d = WR_ACT;
                  OP_DEF:           state_d = WR_DEF;
                  default:          state_d = IDLE;
               endcase
            end
         end
         WR_MASK: state_d = (op_q == OP_ENTRY) ? WR_KEY : IDLE;
         WR_KEY:  state_d = (op_q == OP_ENTRY) ? WR_ACT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: strobes and their address/data load on entry to a state.
   always_comb begin
      cur_idx     = cmd_wr ? cmd_idx : idx_q;
      tcam_en_d   = 1'b0;
      is_mask_d   = 1'b0;
      tcam_addr_d = tcam_addr_q;
      tcam_data_d = tcam_data_q;
      act_en_d    = 1'b0;
      act_addr_d  = act_addr_q;
      act_data_d  = act_data_q;
      def_en_d    = 1'b0;
      def_data_d  = def_data_q;
      err_d       = cmd_err ? 1'b1 : (w1c ? 1'b0 : err_q);
      done_d      = done_q + ((busy && (state_d == IDLE)) ? 8'd1 : 8'd0);
      unique case (state_d)
         WR_MASK: begin
            tcam_en_d   = 1'b1;
            is_mask_d   = 1'b1;
            tcam_addr_d = cur_idx;
            tcam_data_d = mask_q;
         end
         WR_KEY: begin
            tcam_en_d   = 1'b1;
            tcam_addr_d = cur_idx;
            tcam_data_d = key_q;
         end
         WR_ACT: begin
            act_en_d   = 1'b1;
            act_addr_d = cur_idx;
            act_data_d = act_q;
         end
         WR_DEF: begin
            def_en_d   = 1'b1;
            def_data_d = act_q;
         end
         default: ;
      endcase
   end

   // State, staging, status and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         op_q        <= 3'd0;
         idx_q       <= '0;
         key_q       <= '0;
         mask_q      <= '0;
         act_q       <= '0;
         err_q       <= 1'b0;
         done_q      <= 8'd0;
         ready_q     <= 1'b0;
         rdata_q     <= 32'h0;
         tcam_en_q   <= 1'b0;
         is_mask_q   <= 1'b0;
         tcam_addr_q <= '0;
         tcam_data_q <= '0;
         act_en_q    <= 1'b0;
         act_addr_q  <= '0;
         act_data_q  <= '0;
         def_en_q    <= 1'b0;
         def_data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         if (cmd_wr) begin
            op_q  <= cmd_op;
            idx_q <= cmd_idx;
         end
         key_q       <= key_d;
         mask_q      <= mask_d;
         act_q       <= act_d;
         err_q       <= err_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         tcam_en_q   <= tcam_en_d;
         is_mask_q   <= is_mask_d;
         tcam_addr_q <= tcam_addr_d;
         tcam_data_q <= tcam_data_d;
         act_en_q    <= act_en_d;
         act_addr_q  <= act_addr_d;
         act_data_q  <= act_data_d;
         def_en_q    <= def_en_d;
         def_data_q  <= def_data_d;
      end
   end

   assign mem_ready           = ready_q;
   assign mem_rdata           = rdata_q;
   assign tcam_wr_en          = tcam_en_q;
   assign tcam_wr_is_mask     = is_mask_q;
   assign tcam_wr_addr        = tcam_addr_q;
   assign tcam_wr_data        = tcam_data_q;
   assign action_wr_en        = act_en_q;
   assign action_wr_addr      = act_addr_q;
   assign action_wr_data      = act_data_q;
   assign action_wr_default   = def_en_q;
   assign action_default_data = def_data_q;

endmodule

// File: tb/tb_tcam_cfg_ctrl.sv
// Directed testbench for tcam_cfg_ctrl with hand-computed expected values.
module tb_tcam_cfg_ctrl;

   localparam logic [31:0] BASE = 32'h0300_0000;
   localparam logic [7:0]  A_KEY0 = 8'h00, A_KEY1 = 8'h04, A_KEY2 = 8'h08, A_KEY3 = 8'h0C;
   localparam logic [7:0]  A_MASK0 = 8'h10, A_ACT0 = 8'h20, A_ACT1 = 8'h24;
   localparam logic [7:0]  A_CMD = 8'h28, A_STATUS = 8'h2C, A_UNMAP = 8'h40;

   logic         clk = 1'b0;
   logic         resetn;
   logic         mem_valid;
   logic [31:0]  mem_addr, mem_wdata;
   logic [3:0]   mem_wstrb;
   logic         mem_ready;
   logic [31:0]  mem_rdata;
   logic         tcam_wr_en, tcam_wr_is_mask;
   logic [3:0]   tcam_wr_addr;
   logic [127:0] tcam_wr_data;
   logic         action_wr_en;
   logic [3:0]   action_wr_addr;
   logic [63:0]  action_wr_data;
   logic         action_wr_default;
   logic [63:0]  action_default_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Strobe monitor: counts pulses and remembers the last data seen.
   int          act_cnt = 0, def_cnt = 0, tcam_cnt = 0;
   logic [63:0] act_seen = '0, def_seen = '0;

   tcam_cfg_ctrl dut (
      .clk                 (clk),
      .resetn              (resetn),
      .mem_valid           (mem_valid),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_wstrb           (mem_wstrb),
      .mem_ready           (mem_ready),
      .mem_rdata           (mem_rdata),
      .tcam_wr_en          (tcam_wr_en),
      .tcam_wr_is_mask     (tcam_wr_is_mask),
      .tcam_wr_addr        (tcam_wr_addr),
      .tcam_wr_data        (tcam_wr_data),
      .action_wr_en        (action_wr_en),
      .action_wr_addr      (action_wr_addr),
      .action_wr_data      (action_wr_data),
      .action_wr_default   (action_wr_default),
      .action_default_data (action_default_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tcam_wr_en) tcam_cnt++;
      if (action_wr_en) begin
         act_cnt++;
         act_seen = action_wr_data;
      end
      if (action_wr_default) begin
         def_cnt++;
         def_seen = action_default_data;
      end
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One bus transfer; returns read data and the number of edges until ack.
   task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int waits);
      mem_addr  = BASE | {24'h0, off};
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_valid = 1'b1;
      waits     = 0;
      while (!mem_ready && waits < 20) begin
         @(posedge clk);
         #1;
         waits++;
      end
      check("bus_ack", {127'b0, mem_ready}, 128'd1);
      rd = mem_rdata;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] wd);
      logic [31:0] r;
      int          w;
      bus(off, wd, 4'hF, r, w);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] r;
      int          w;
      bus(off, 32'h0, 4'h0, r, w);
      check(tag, {96'b0, r}, {96'b0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      int          w, a0, d0, t0;

      resetn    = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {127'b0, mem_ready}, 128'd0);
      check("rst_tcam_en", {127'b0, tcam_wr_en}, 128'd0);
      check("rst_tcam_data", tcam_wr_data, 128'd0);
      check("rst_act_data", {64'b0, action_wr_data}, 128'd0);
      @(negedge clk);
      resetn = 1'b1;
      step();
      rd_chk("rst_status", A_STATUS, 32'h0);
      rd_chk("rst_key0", A_KEY0, 32'h0);

      // Out-of-window access is never acknowledged.
      mem_addr  = 32'h0400_0000;
      mem_wstrb = 4'h0;
      mem_valid = 1'b1;
      repeat (3) step();
      check("miss_noack", {127'b0, mem_ready}, 128'd0);
      mem_valid = 1'b0;
      step();

      // Single KEY command.
      wr(A_KEY0, 32'h1111_1111);
      wr(A_KEY1, 32'h2222_2222);
      wr(A_KEY2, 32'h3333_3333);
      wr(A_KEY3, 32'h4444_4444);
      rd_chk("key2_rb", A_KEY2, 32'h3333_3333);
      wr(A_CMD, 32'h0000_0105);
      check("key_en_t1", {127'b0, tcam_wr_en}, 128'd1);
      check("key_ismask_t1", {127'b0, tcam_wr_is_mask}, 128'd0);
      check("key_addr_t1", {124'b0, tcam_wr_addr}, 128'd5);
      check("key_data_t1", tcam_wr_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
      check("key_busy_t1", {127'b0, dut.busy}, 128'd1);
      step();
      check("key_en_t2", {127'b0, tcam_wr_en}, 128'd0);
      check("key_addr_hold", {124'b0, tcam_wr_addr}, 128'd5);
      rd_chk("key_status", A_STATUS, 32'h0000_0100);

      // ENTRY command: mask, key, action on consecutive cycles.
      for (int i = 0; i < 4; i++) wr(A_MASK0 + 8'(i * 4), 32'hFFFF_0000);
      wr(A_ACT0, 32'hCAFE_F00D);
      wr(A_ACT1, 32'hDEAD_BEEF);
      wr(A_CMD, 32'h0000_050F);
      check("ent_t1_en", {126'b0, tcam_wr_en, tcam_wr_is_mask}, 128'd3);
      check("ent_t1_addr", {124'b0, tcam_wr_addr}, 128'd15);
      check("ent_t1_data", tcam_wr_data, {4{32'hFFFF_0000}});
      check("ent_t1_busy", {127'b0, dut.busy}, 128'd1);
      step();
      check("ent_t2_en", {126'b0, tcam_wr_en, tcam_wr_is_mask}, 128'd2);
      check("ent_t2_data", tcam_wr_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
      check("ent_t2_busy", {127'b0, dut.busy}, 128'd1);
      step();
      check("ent_t3_tcam_en", {127'b0, tcam_wr_en}, 128'd0);
      check("ent_t3_act_en", {127'b0, action_wr_en}, 128'd1);
      check("ent_t3_act_addr", {124'b0, action_wr_addr}, 128'd15);
      check("ent_t3_act_data", {64'b0, action_wr_data}, 128'hDEAD_BEEF_CAFE_F00D);
      check("ent_t3_busy", {127'b0, dut.busy}, 128'd1);
      step();
      check("ent_t4_act_en", {127'b0, action_wr_en}, 128'd0);
      rd_chk("ent_status", A_STATUS, 32'h0000_0200);

      // Bus stall: ACT_W0 write right after an ENTRY command waits for IDLE.
      a0 = act_cnt;
      wr(A_CMD, 32'h0000_0503);
      bus(A_ACT0, 32'h1234_5678, 4'hF, r, w);
      check("stall_waits", 128'(w), 128'd4);
      check("stall_act_cnt", 128'(act_cnt - a0), 128'd1);
      check("stall_act_old", {64'b0, act_seen}, 128'hDEAD_BEEF_CAFE_F00D);
      check("stall_act_addr", {124'b0, action_wr_addr}, 128'd3);
      rd_chk("stall_act0_rb", A_ACT0, 32'h1234_5678);

      // Illegal op, W1C of err, byte-lane write, unmapped and CMD reads.
      t0 = tcam_cnt; a0 = act_cnt; d0 = def_cnt;
      wr(A_CMD, 32'h0000_0700);
      step();
      check("err_no_strobe", 128'((tcam_cnt - t0) + (act_cnt - a0) + (def_cnt - d0)), 128'd0);
      rd_chk("err_status", A_STATUS, 32'h0000_0302);
      wr(A_STATUS, 32'h0000_0002);
      rd_chk("err_cleared", A_STATUS, 32'h0000_0300);
      bus(A_KEY1, 32'h0000_AB00, 4'b0010, r, w);
      rd_chk("byte_key1", A_KEY1, 32'h2222_AB22);
      rd_chk("byte_key0", A_KEY0, 32'h1111_1111);
      wr(A_UNMAP, 32'hFFFF_FFFF);
      rd_chk("unmap_rd", A_UNMAP, 32'h0);
      rd_chk("cmd_rd", A_CMD, 32'h0);

      // Reset in the middle of an ENTRY sequence.
      wr(A_CMD, 32'h0000_0507);
      check("rst_ent_t1", {126'b0, tcam_wr_en, tcam_wr_is_mask}, 128'd3);
      step();
      check("rst_ent_t2", {126'b0, tcam_wr_en, tcam_wr_is_mask}, 128'd2);
      a0 = act_cnt;
      resetn = 1'b0;
      #1;
      check("rst_async_tcam", {127'b0, tcam_wr_en}, 128'd0);
      check("rst_async_addr", {124'b0, tcam_wr_addr}, 128'd0);
      check("rst_async_act_addr", {124'b0, action_wr_addr}, 128'd0);
      check("rst_async_act_data", {64'b0, action_wr_data}, 128'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) step();
      check("rst_no_act", 128'(act_cnt - a0), 128'd0);
      check("rst_outs", {125'b0, tcam_wr_en, action_wr_en, action_wr_default}, 128'd0);
      rd_chk("rst_mid_status", A_STATUS, 32'h0);
      rd_chk("rst_mid_act0", A_ACT0, 32'h0);

      // 256 DEFAULT commands: done_cnt wraps back to 0.
      wr(A_ACT0, 32'h00C0_FFEE);
      wr(A_ACT1, 32'h0BAD_F00D);
      d0 = def_cnt; a0 = act_cnt;
      for (int i = 0; i < 256; i++) begin
         wr(A_CMD, 32'h0000_0400 | 32'(i % 16));
         if (i == 254) rd_chk("def_cnt_255", A_STATUS, 32'h0000_FF00);
      end
      step();
      check("def_pulses", 128'(def_cnt - d0), 128'd256);
      check("def_no_act", 128'(act_cnt - a0), 128'd0);
      check("def_data", {64'b0, def_seen}, 128'h0BAD_F00D_00C0_FFEE);
      rd_chk("def_wrap", A_STATUS, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tcam_cfg_ctrl.md
Name: tcam_cfg_ctrl

Overview:
Memory-mapped configuration controller between the PicoRV32 native memory bus and the dataplane's TCAM/action-table config ports. Firmware fills staging registers for key, mask and action through 32-bit bus writes, then issues a command. An FSM turns each command into a sequence of single-cycle write strobes on the cfg_tcam_wr_* and cfg_action_wr_* outputs. It replaces direct GPIO-style driving of the 128-bit config buses.

Parameters:
BASE_ADDR, 32'h0300_0000, bus window base; block decodes mem_addr[31:8] == BASE_ADDR[31:8]
KEY_W, 128, TCAM key/mask width (multiple of 32)
ENTRIES, 16, table depth; IDX_W = $clog2(ENTRIES)
ACTION_W, 64, action word width (multiple of 32)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  PicoRV32 bus request
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables; 0 = read
mem_ready  out  1  single-cycle transfer acknowledge
mem_rdata  out  32  read data, valid while mem_ready=1
tcam_wr_en  out  1  TCAM write strobe
tcam_wr_is_mask  out  1  1 = mask plane, 0 = key plane
tcam_wr_addr  out  IDX_W  TCAM entry index
tcam_wr_data  out  KEY_W  key or mask data
action_wr_en  out  1  action-table write strobe
action_wr_addr  out  IDX_W  action entry index
action_wr_data  out  ACTION_W  action data
action_wr_default  out  1  default-action write strobe
action_default_data  out  ACTION_W  default action data

Behaviour:
- Reset (async, resetn=0): all outputs, staging registers, FSM, status and counter cleared to 0. FSM returns to IDLE from any state. An in-flight sequence is abandoned and no further strobes are issued.
- Register map (offset): 0x00-0x0C KEY_W0..3 RW; 0x10-0x1C MASK_W0..3 RW; 0x20-0x24 ACT_W0..1 RW; 0x28 CMD WO; 0x2C STATUS.
  - Word 0 = bits [31:0].
  - Staging writes honour mem_wstrb per byte.
  - Unmapped offsets read 0 and ignore writes.
- Bus handshake:
  - On mem_valid && hit && !mem_ready, assert mem_ready for exactly one cycle on the next edge. Register write and read capture occur in that cycle.
  - Miss: mem_ready stays 0.
  - Any access with a hit while busy=1 is stalled: mem_ready is withheld until the FSM reaches IDLE. This keeps staging data stable during a sequence.
- CMD fields: [IDX_W-1:0] idx; [10:8] op.
  - op 1 = KEY
  - op 2 = MASK
  - op 3 = ACTION
  - op 4 = DEFAULT (idx ignored)
  - op 5 = ENTRY (MASK, then KEY, then ACTION, all at idx)
  - op 0/6/7: no strobe; sets STATUS.err.
- Timing: the CMD write acknowledged in cycle T launches the sequence.
  - Single ops: exactly one strobe in cycle T+1.
  - ENTRY: tcam_wr_en+is_mask=1 at T+1; tcam_wr_en+is_mask=0 at T+2; action_wr_en at T+3.
  - FSM states: IDLE, WR_MASK, WR_KEY, WR_ACT, WR_DEF. Each state lasts one cycle and returns to IDLE.
- Outputs are registered. Strobes are high for exactly one cycle.
  - Address and data outputs are loaded in the same cycle as their strobe and hold their value afterwards.
  - tcam_wr_is_mask is meaningful only while tcam_wr_en=1.
- STATUS:
  - bit0 busy: 1 in every non-IDLE cycle.
  - bit1 err: sticky; cleared by writing 1 to bit1.
  - bits[15:8] done_cnt: increments once per completed valid command, wraps 255 to 0.
  - If an err set and a W1C occur in the same cycle, set wins.
- CMD reads return 0.

Test Plan:
- Reset mid-ENTRY: assert resetn=0 at T+2 -> no action_wr_en is issued, all outputs are 0, STATUS reads 0 after reset.
- Write KEY_W0..3 = 0x11111111..0x44444444, then CMD op=1 idx=5 -> tcam_wr_en=1 for 1 cycle at T+1 with addr=5, is_mask=0, data=0x44444444_33333333_22222222_11111111; done_cnt=1.
- ENTRY: staged mask 0xFFFF_0000..., ACT = 0xDEADBEEF_CAFEF00D, CMD op=5 idx=15 -> mask strobe at T+1, key strobe at T+2, action strobe at T+3 (addr 15, data 0xDEADBEEFCAFEF00D); busy reads 1 in T+1..T+3.
- Bus stall: write ACT_W0 one cycle after an ENTRY CMD -> mem_ready is delayed until IDLE; the action strobe carries the old ACT value.
- CMD op=7 -> no strobes, err=1; write STATUS=0x2 -> err=0; byte write with wstrb=4'b0010, data 0x0000AB00 to KEY_W1 -> only bits [47:40] change.
- Issue 256 DEFAULT commands -> action_wr_default pulses 256 times with action_default_data = staged ACT; done_cnt wraps to 0.
